// File: rtl/axi4_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_rd_arbiter
//   Round-robin arbiter that shares one AXI4 read slave among NUM_MST read
//   masters. One master is granted, its AR is forwarded once (registered),
//   then the R burst is routed back to it until the last beat, after which
//   the arbiter re-arbitrates. Only one read is outstanding at a time.
//
// Optional feature (compile-time macro ARB_LAST_CHECK_EN):
//   defined   : a beat counter generates the master-side RLAST from the
//               captured ARLEN, the burst ends on that generated last, and
//               o_err pulses for one cycle when the slave RLAST disagrees
//               with it at a beat.
//   undefined : RLAST is passed through from the slave, the burst ends on
//               the slave RLAST, and o_err is tied low.
//
// Ports
//   i_aclk, i_areset                 clock, asynchronous active-high reset
//   i_m_ar* / o_m_arready            per-master AR channels (packed per master)
//   o_m_rid/rdata/rresp/rlast        R payload broadcast to all masters
//   o_m_rvalid / i_m_rready          per-master R handshake
//   o_s_ar* / i_s_arready            registered AR towards the slave
//   i_s_r* / o_s_rready              R channel from the slave
//   o_grant                          one-hot current owner, 0 when idle
//   o_err                            protocol error pulse
// ---------------------------------------------------------------------------
module axi4_rd_arbiter #(
   parameter int NUM_MST = 2,
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 64,
   parameter int LEN_W   = 8
) (
   input  logic                      i_aclk,
   input  logic                      i_areset,
   input  logic [NUM_MST*ID_W-1:0]   i_m_arid,
   input  logic [NUM_MST*ADDR_W-1:0] i_m_araddr,
   input  logic [NUM_MST*LEN_W-1:0]  i_m_arlen,
   input  logic [NUM_MST*3-1:0]      i_m_arsize,
   input  logic [NUM_MST*2-1:0]      i_m_arburst,
   input  logic [NUM_MST-1:0]        i_m_arvalid,
   output logic [NUM_MST-1:0]        o_m_arready,
   output logic [ID_W-1:0]           o_m_rid,
   output logic [DATA_W-1:0]         o_m_rdata,
   output logic [1:0]                o_m_rresp,
   output logic                      o_m_rlast,
   output logic [NUM_MST-1:0]        o_m_rvalid,
   input  logic [NUM_MST-1:0]        i_m_rready,
   output logic [ID_W-1:0]           o_s_arid,
   output logic [ADDR_W-1:0]         o_s_araddr,
   output logic [LEN_W-1:0]          o_s_arlen,
   output logic [2:0]                o_s_arsize,
   output logic [1:0]                o_s_arburst,
   output logic                      o_s_arvalid,
   input  logic                      i_s_arready,
   input  logic [ID_W-1:0]           i_s_rid,
   input  logic [DATA_W-1:0]         i_s_rdata,
   input  logic [1:0]                i_s_rresp,
   input  logic                      i_s_rlast,
   input  logic                      i_s_rvalid,
   output logic                      o_s_rready,
   output logic [NUM_MST-1:0]        o_grant,
   output logic                      o_err
);

   localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10
   } state_t;

   state_t              state_r;
   logic [IDX_W-1:0]    ptr_r;
   logic [IDX_W-1:0]    gidx_r;
   logic [NUM_MST-1:0]  grant_r;
   logic [ID_W-1:0]     s_arid_r;
   logic [ADDR_W-1:0]   s_araddr_r;
   logic [LEN_W-1:0]    s_arlen_r;
   logic [2:0]          s_arsize_r;
   logic [1:0]          s_arburst_r;
   logic                s_arvalid_r;

   logic                req_any_s;
   logic [IDX_W-1:0]    pick_s;
   logic                beat_s;
   logic                last_s;

`ifdef ARB_LAST_CHECK_EN
   logic [LEN_W-1:0]    cnt_r;
   logic                err_r;
   logic                gen_last_s;
`endif

   // First requesting master at or after the pointer, searching cyclically.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               idx;
      sel   = {IDX_W{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NUM_MST; i++) begin
         idx = (int'(ptr) + i) % NUM_MST;
         if (!found && req[idx]) begin
            sel   = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign req_any_s   = |i_m_arvalid;
   assign pick_s      = rr_pick(i_m_arvalid, ptr_r);

   assign o_s_arid    = s_arid_r;
   assign o_s_araddr  = s_araddr_r;
   assign o_s_arlen   = s_arlen_r;
   assign o_s_arsize  = s_arsize_r;
   assign o_s_arburst = s_arburst_r;
   assign o_s_arvalid = s_arvalid_r;
   assign o_grant     = grant_r;

`ifdef ARB_LAST_CHECK_EN
   assign gen_last_s  = (cnt_r == s_arlen_r);
   assign o_err       = err_r;
`else
   assign o_err       = 1'b0;
`endif

   // Handshake steering: AR accept in idle, zero-latency R passthrough in data.
   always_comb begin
      o_m_arready = {NUM_MST{1'b0}};
      o_m_rvalid  = {NUM_MST{1'b0}};
      o_s_rready  = 1'b0;
      o_m_rid     = {ID_W{1'b0}};
      o_m_rdata   = {DATA_W{1'b0}};
      o_m_rresp   = 2'b00;
      o_m_rlast   = 1'b0;
      beat_s      = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_any_s) begin
               o_m_arready[pick_s] = 1'b1;
            end else begin
               o_m_arready = {NUM_MST{1'b0}};
            end
         end
         S_DATA: begin
            o_m_rvalid[gidx_r] = i_s_rvalid;
            o_s_rready         = i_m_rready[gidx_r];
            o_m_rid            = i_s_rid;
            o_m_rdata          = i_s_rdata;
            o_m_rresp          = i_s_rresp;
            beat_s             = i_s_rvalid && i_m_rready[gidx_r];
`ifdef ARB_LAST_CHECK_EN
            o_m_rlast          = gen_last_s;
            last_s             = gen_last_s;
`else
            o_m_rlast          = i_s_rlast;
            last_s             = i_s_rlast;
`endif
         end
         default: begin
            o_s_rready = 1'b0;
         end
      endcase
   end

   // Arbitration FSM with registered grant, slave AR and error outputs.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         state_r     <= S_IDLE;
         ptr_r       <= {IDX_W{1'b0}};
         gidx_r      <= {IDX_W{1'b0}};
         grant_r     <= {NUM_MST{1'b0}};
         s_arid_r    <= {ID_W{1'b0}};
         s_araddr_r  <= {ADDR_W{1'b0}};
         s_arlen_r   <= {LEN_W{1'b0}};
         s_arsize_r  <= 3'b000;
         s_arburst_r <= 2'b00;
         s_arvalid_r <= 1'b0;
`ifdef ARB_LAST_CHECK_EN
         cnt_r       <= {LEN_W{1'b0}};
         err_r       <= 1'b0;
`endif
      end else begin
`ifdef ARB_LAST_CHECK_EN
         err_r <= 1'b0;
`endif
         case (state_r)
            S_IDLE: begin
               if (req_any_s) begin
                  s_arid_r    <= i_m_arid[pick_s*ID_W +: ID_W];
                  s_araddr_r  <= i_m_araddr[pick_s*ADDR_W +: ADDR_W];
                  s_arlen_r   <= i_m_arlen[pick_s*LEN_W +: LEN_W];
                  s_arsize_r  <= i_m_arsize[pick_s*3 +: 3];
                  s_arburst_r <= i_m_arburst[pick_s*2 +: 2];
                  s_arvalid_r <= 1'b1;
                  grant_r     <= {{(NUM_MST-1){1'b0}}, 1'b1} << pick_s;
                  gidx_r      <= pick_s;
`ifdef ARB_LAST_CHECK_EN
                  cnt_r       <= {LEN_W{1'b0}};
`endif
                  state_r     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (i_s_arready) begin
                  s_arvalid_r <= 1'b0;
                  state_r     <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_s) begin
`ifdef ARB_LAST_CHECK_EN
                  cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                  err_r <= (i_s_rlast != gen_last_s);
`endif
                  if (last_s) begin
                     state_r <= S_IDLE;
                     grant_r <= {NUM_MST{1'b0}};
                     ptr_r   <= (gidx_r == IDX_W'(NUM_MST-1)) ? {IDX_W{1'b0}}
                                                              : gidx_r + IDX_W'(1'b1);
                  end
               end
            end
            default: begin
               // Unused encoding: recover to a clean idle.
               state_r     <= S_IDLE;
               grant_r     <= {NUM_MST{1'b0}};
               s_arvalid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
